// File: rtl/uart_pkg.sv
// Shared types and default constants for the framed UART program loader.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CSUM,
        WRITE,
        RESP
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT  = 8'h06;
    localparam logic [7:0] NAK_DEFAULT  = 8'h15;

    // Expected checksum byte for a frame: XOR of sync, address and data.
    function automatic logic [7:0] frame_csum(input logic [7:0] sync_b,
                                              input logic [7:0] addr_b,
                                              input logic [7:0] data_b);
        return sync_b ^ addr_b ^ data_b;
    endfunction

endpackage

// File: rtl/uart_timeout.sv
// Clearable saturating idle counter; tc is high once TIMEOUT_CLKS-1 clocks
// have elapsed since the last clear and stays high until cleared again.
module uart_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tc
);

    localparam int unsigned   W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [W-1:0]  LAST = W'(TIMEOUT_CLKS - 1);

    logic [W-1:0] count;

    // Count idle clocks, restart on clear, hold at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/uart_prog_loader.sv
// Framed program loader: parses SYNC/ADDR/DATA/CSUM frames from the UART
// receiver, writes validated bytes to program RAM and answers ACK or NAK.
module uart_prog_loader
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
    parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE     = NAK_DEFAULT,
    parameter int unsigned TIMEOUT_CLKS = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    input  logic       tx_active,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       frame_err,
    output logic       busy,
    output logic [3:0] good_count
);

    state_t     state;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic       tmo_clr;
    logic       tmo_hit;
    logic       frame_ok;

    // Held clear in IDLE so the count starts from zero on entering ADDR.
    assign tmo_clr = rx_dv || (state == IDLE);

    uart_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tmo_clr),
        .tc   (tmo_hit)
    );

    assign frame_ok = (addr_q[7:4] == 4'h0) &&
                      (rx_byte == frame_csum(SYNC_BYTE, addr_q, data_q));

    // Frame parser FSM with registered strobes and RAM/response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
            good_count <= '0;
        end else begin
            mem_we    <= 1'b0;
            tx_dv     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv && rx_byte == SYNC_BYTE) begin
                        state <= ADDR;
                        busy  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (rx_dv) begin
                        addr_q <= rx_byte;
                        state  <= DATA;
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        data_q <= rx_byte;
                        state  <= CSUM;
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                CSUM: begin
                    if (rx_dv) begin
                        if (frame_ok) begin
                            // Write strobe is registered here so it is
                            // visible exactly during the WRITE cycle.
                            mem_we   <= 1'b1;
                            mem_addr <= addr_q[3:0];
                            mem_data <= data_q;
                            state    <= WRITE;
                        end else begin
                            frame_err <= 1'b1;
                            tx_byte   <= NAK_BYTE;
                            state     <= RESP;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                WRITE: begin
                    good_count <= good_count + 4'd1;
                    tx_byte    <= ACK_BYTE;
                    state      <= RESP;
                end
                RESP: begin
                    if (!tx_active) begin
                        tx_dv <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader (TIMEOUT_CLKS = 100).
module tb_uart_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_active;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       frame_err;
    logic       busy;
    logic [3:0] good_count;

    int total;
    int bad;

    // Event log filled by the negedge monitor.
    int         pcyc;
    int         rx_cyc;
    int         we_cnt, we_cyc;
    logic [3:0] last_addr;
    logic [7:0] last_data;
    int         tx_cnt, tx_cyc;
    logic [7:0] last_tx;
    int         ferr_cnt, ferr_cyc;

    uart_prog_loader #(
        .TIMEOUT_CLKS(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_active (tx_active),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .frame_err (frame_err),
        .busy      (busy),
        .good_count(good_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pcyc = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    initial begin
        rx_cyc = 0; we_cnt = 0; we_cyc = 0; tx_cnt = 0; tx_cyc = 0;
        ferr_cnt = 0; ferr_cyc = 0; last_addr = '0; last_data = '0; last_tx = '0;
    end

    always @(negedge clk) begin
        if (rx_dv) rx_cyc = pcyc;
        if (mem_we) begin
            we_cnt++; we_cyc = pcyc; last_addr = mem_addr; last_data = mem_data;
        end
        if (tx_dv) begin
            tx_cnt++; tx_cyc = pcyc; last_tx = tx_byte;
        end
        if (frame_err) begin
            ferr_cnt++; ferr_cyc = pcyc;
        end
    end

    // All tasks start and end 2 time units after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1;
        rx_byte = b;
        idle(1);
        rx_dv = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_dv = 1'b0; rx_byte = '0; tx_active = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if ({tx_dv, tx_byte, mem_we, mem_addr, mem_data, frame_err, busy, good_count} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {tx_dv, tx_byte, mem_we, mem_addr, mem_data, frame_err, busy, good_count});
        end
        rst_n = 1'b1;
        idle(2);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_good_frame;
        int w0, t0, f0;
        w0 = we_cnt; t0 = tx_cnt; f0 = ferr_cnt;
        send_frame(8'h03, 8'h7E, 8'hD8);
        idle(8);
        total++;
        if (we_cnt - w0 !== 1) begin bad++; $display("FAIL good_we_count: got %0d want 1", we_cnt - w0); end
        total++;
        if ({last_addr, last_data} !== 12'h37E) begin
            bad++; $display("FAIL good_write: got %h want 37e", {last_addr, last_data});
        end
        total++;
        if (we_cyc !== rx_cyc + 1) begin bad++; $display("FAIL good_we_latency: got %0d want %0d", we_cyc - rx_cyc, 1); end
        total++;
        if (tx_cnt - t0 !== 1 || last_tx !== 8'h06) begin
            bad++; $display("FAIL good_ack: got n=%0d byte=%h want n=1 byte=06", tx_cnt - t0, last_tx);
        end
        total++;
        if (tx_cyc !== rx_cyc + 3) begin bad++; $display("FAIL good_ack_latency: got %0d want 3", tx_cyc - rx_cyc); end
        total++;
        if (good_count !== 4'd1) begin bad++; $display("FAIL good_count1: got %0d want 1", good_count); end
        total++;
        if (ferr_cnt - f0 !== 0) begin bad++; $display("FAIL good_no_err: got %0d want 0", ferr_cnt - f0); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_bad_csum;
        int w0, t0, f0;
        w0 = we_cnt; t0 = tx_cnt; f0 = ferr_cnt;
        send_frame(8'h03, 8'h7E, 8'h00);
        idle(8);
        total++;
        if (we_cnt - w0 !== 0) begin bad++; $display("FAIL csum_no_we: got %0d want 0", we_cnt - w0); end
        total++;
        if (ferr_cnt - f0 !== 1 || ferr_cyc !== rx_cyc + 1) begin
            bad++; $display("FAIL csum_err: got n=%0d lat=%0d want n=1 lat=1", ferr_cnt - f0, ferr_cyc - rx_cyc);
        end
        total++;
        if (tx_cnt - t0 !== 1 || last_tx !== 8'h15 || tx_cyc !== rx_cyc + 2) begin
            bad++; $display("FAIL csum_nak: got n=%0d byte=%h lat=%0d want n=1 byte=15 lat=2",
                            tx_cnt - t0, last_tx, tx_cyc - rx_cyc);
        end
        total++;
        if ({mem_addr, mem_data} !== 12'h37E || good_count !== 4'd1) begin
            bad++; $display("FAIL csum_hold: got %h cnt=%0d want 37e cnt=1", {mem_addr, mem_data}, good_count);
        end
    endtask

    task automatic test_bad_addr;
        int w0, t0, f0;
        w0 = we_cnt; t0 = tx_cnt; f0 = ferr_cnt;
        send_frame(8'h13, 8'h7E, 8'hC8);
        idle(8);
        total++;
        if (we_cnt - w0 !== 0) begin bad++; $display("FAIL addr_no_we: got %0d want 0", we_cnt - w0); end
        total++;
        if (tx_cnt - t0 !== 1 || last_tx !== 8'h15) begin
            bad++; $display("FAIL addr_nak: got n=%0d byte=%h want n=1 byte=15", tx_cnt - t0, last_tx);
        end
        total++;
        if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL addr_err: got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_garbage;
        int w0, t0;
        w0 = we_cnt; t0 = tx_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h0F, 8'h01, 8'hAB);
        idle(8);
        total++;
        if (we_cnt - w0 !== 1 || {last_addr, last_data} !== 12'hF01) begin
            bad++; $display("FAIL garbage_write: got n=%0d %h want n=1 f01", we_cnt - w0, {last_addr, last_data});
        end
        total++;
        if (tx_cnt - t0 !== 1 || last_tx !== 8'h06) begin
            bad++; $display("FAIL garbage_ack: got n=%0d byte=%h want n=1 byte=06", tx_cnt - t0, last_tx);
        end
        total++;
        if (good_count !== 4'd2) begin bad++; $display("FAIL garbage_count: got %0d want 2", good_count); end
    endtask

    task automatic test_timeout;
        int w0, t0, f0, sent_cyc;
        w0 = we_cnt; t0 = tx_cnt; f0 = ferr_cnt;
        send_byte(8'hA5);
        send_byte(8'h03);
        sent_cyc = rx_cyc;
        for (int i = 0; i < 150 && ferr_cnt == f0; i++) idle(1);
        idle(3);
        total++;
        if (ferr_cnt - f0 !== 1) begin bad++; $display("FAIL timeout_err: got %0d want 1", ferr_cnt - f0); end
        total++;
        if (ferr_cyc !== sent_cyc + 101) begin
            bad++; $display("FAIL timeout_latency: got %0d want 101", ferr_cyc - sent_cyc);
        end
        total++;
        if (busy !== 1'b0 || tx_cnt - t0 !== 0 || we_cnt - w0 !== 0) begin
            bad++; $display("FAIL timeout_quiet: got busy=%b tx=%0d we=%0d want 0 0 0", busy, tx_cnt - t0, we_cnt - w0);
        end
        send_frame(8'h05, 8'h3C, 8'h9C);
        idle(8);
        total++;
        if (we_cnt - w0 !== 1 || {last_addr, last_data} !== 12'h53C || last_tx !== 8'h06) begin
            bad++; $display("FAIL timeout_recover: got n=%0d %h tx=%h want n=1 53c tx=06",
                            we_cnt - w0, {last_addr, last_data}, last_tx);
        end
    endtask

    task automatic test_tx_active;
        int t0, fall;
        t0 = tx_cnt;
        tx_active = 1'b1;
        send_frame(8'h07, 8'h11, 8'hB3);
        idle(46);
        total++;
        if (tx_cnt - t0 !== 0 || busy !== 1'b1) begin
            bad++; $display("FAIL txact_hold: got tx=%0d busy=%b want 0 1", tx_cnt - t0, busy);
        end
        tx_active = 1'b0;
        fall = pcyc;
        for (int i = 0; i < 10 && tx_cnt == t0; i++) idle(1);
        idle(2);
        total++;
        if (tx_cnt - t0 !== 1 || tx_cyc !== fall + 1 || last_tx !== 8'h06) begin
            bad++; $display("FAIL txact_release: got n=%0d delay=%0d byte=%h want n=1 delay=1 byte=06",
                            tx_cnt - t0, tx_cyc - fall, last_tx);
        end
    endtask

    task automatic test_wrap;
        int w0;
        logic [7:0] a, d;
        w0 = we_cnt;
        for (int i = 0; i < 12; i++) begin
            a = 8'(i);
            d = 8'(i * 17 + 1);
            send_frame(a, d, 8'hA5 ^ a ^ d);
            idle(6);
            if (i == 10) begin
                total++;
                if (good_count !== 4'd15) begin bad++; $display("FAIL wrap_15: got %0d want 15", good_count); end
            end
        end
        total++;
        if (good_count !== 4'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", good_count); end
        total++;
        if (we_cnt - w0 !== 12) begin bad++; $display("FAIL wrap_writes: got %0d want 12", we_cnt - w0); end
    endtask

    task automatic test_reset_mid;
        int w0, t0;
        send_frame(8'h01, 8'h22, 8'h86);
        idle(8);
        w0 = we_cnt; t0 = tx_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h33);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        send_byte(8'h94);
        idle(8);
        total++;
        if (we_cnt - w0 !== 0 || tx_cnt - t0 !== 0) begin
            bad++; $display("FAIL midreset_quiet: got we=%0d tx=%0d want 0 0", we_cnt - w0, tx_cnt - t0);
        end
        total++;
        if ({busy, good_count, mem_addr, mem_data, tx_byte} !== 25'h0) begin
            bad++; $display("FAIL midreset_state: got %h want 0", {busy, good_count, mem_addr, mem_data, tx_byte});
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_addr();
        test_garbage();
        test_timeout();
        test_tx_active();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
